// File: rtl/stc_pe_seq_if.sv
// Operand and result valid/ready streams of the sparse PE sequencer.
interface stc_pe_seq_if #(
  parameter int N_UNIT  = 64,
  parameter int DW_DATA = 32
);
  logic                        op_valid;
  logic                        op_ready;
  logic [N_UNIT*DW_DATA-1:0]   op_a;
  logic [N_UNIT*DW_DATA-1:0]   op_b;
  logic                        res_valid;
  logic                        res_ready;
  logic [N_UNIT*DW_DATA-1:0]   res_data;

  modport master (
    output op_valid, op_a, op_b, res_ready,
    input  op_ready, res_valid, res_data
  );

  modport slave (
    input  op_valid, op_a, op_b, res_ready,
    output op_ready, res_valid, res_data
  );
endinterface

// File: rtl/stc_pe_seq.sv
// Job sequencer and per-lane accumulator around the sparse PE multiplier array.
module stc_pe_seq #(
  parameter int N_UNIT  = 64,
  parameter int DW_DATA = 32,
  parameter int DW_CNT  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DW_CNT-1:0]          k_len,
  output logic                       busy,
  output logic                       done,
  stc_pe_seq_if.slave                bus,
  output logic [N_UNIT*DW_DATA-1:0]  pe_a,
  output logic [N_UNIT*DW_DATA-1:0]  pe_b,
  input  logic [N_UNIT*DW_DATA-1:0]  pe_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT
  } state_t;

  state_t              state;
  logic [DW_CNT-1:0]   cnt;
  logic [DW_CNT-1:0]   klen_r;
  logic                p_v;
  logic                op_ready_r;
  logic                res_valid_r;
  logic [DW_DATA-1:0]  acc [N_UNIT];
  logic                fire;

  assign fire          = bus.op_valid && op_ready_r;
  assign bus.op_ready  = op_ready_r;
  assign bus.res_valid = res_valid_r;

  // The array only ever sees accepted beats or zeros.
  assign pe_a = fire ? bus.op_a : '0;
  assign pe_b = fire ? bus.op_b : '0;

  always_comb begin
    bus.res_data = '0;
    for (int unsigned i = 0; i < N_UNIT; i++) begin
      bus.res_data[i*DW_DATA +: DW_DATA] = acc[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      klen_r      <= '0;
      p_v         <= 1'b0;
      op_ready_r  <= 1'b0;
      res_valid_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int unsigned i = 0; i < N_UNIT; i++) acc[i] <= '0;
    end else begin
      done <= 1'b0;
      p_v  <= fire;
      // Products land one cycle after their beat fired, independent of state.
      if (p_v) begin
        for (int unsigned i = 0; i < N_UNIT; i++) begin
          acc[i] <= acc[i] + pe_out[i*DW_DATA +: DW_DATA];
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            klen_r <= k_len;
            cnt    <= '0;
            busy   <= 1'b1;
            for (int unsigned i = 0; i < N_UNIT; i++) acc[i] <= '0;
            if (k_len == '0) begin
              state       <= OUT;
              res_valid_r <= 1'b1;
            end else begin
              state      <= RUN;
              op_ready_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fire) begin
            cnt <= cnt + DW_CNT'(1);
            if (cnt == klen_r - DW_CNT'(1)) begin
              state      <= DRAIN;
              op_ready_r <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state       <= OUT;
          res_valid_r <= 1'b1;
        end
        OUT: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_r <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stc_pe_seq.sv
// Directed bench for stc_pe_seq with a 1-cycle registered multiplier array model.
module tb_stc_pe_seq;
  localparam int N_UNIT  = 4;
  localparam int DW_DATA = 32;
  localparam int DW_CNT  = 16;
  localparam int W       = N_UNIT*DW_DATA;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DW_CNT-1:0] k_len;
  logic              busy, done;
  logic [W-1:0]      pe_a, pe_b, pe_out;

  int n_assert = 0;
  int n_fail   = 0;

  stc_pe_seq_if #(.N_UNIT(N_UNIT), .DW_DATA(DW_DATA)) bus ();

  stc_pe_seq #(.N_UNIT(N_UNIT), .DW_DATA(DW_DATA), .DW_CNT(DW_CNT)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .k_len  (k_len),
    .busy   (busy),
    .done   (done),
    .bus    (bus.slave),
    .pe_a   (pe_a),
    .pe_b   (pe_b),
    .pe_out (pe_out)
  );

  always #5 clk = ~clk;

  // PE array model: lane product truncated to DW_DATA, shares reset.
  always_ff @(posedge clk) begin
    if (reset) pe_out <= '0;
    else begin
      for (int i = 0; i < N_UNIT; i++)
        pe_out[i*DW_DATA +: DW_DATA] <= pe_a[i*DW_DATA +: DW_DATA] * pe_b[i*DW_DATA +: DW_DATA];
    end
  end

  function automatic logic [W-1:0] rep(input logic [DW_DATA-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < N_UNIT; i++) r[i*DW_DATA +: DW_DATA] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] lanes(input logic [DW_DATA-1:0] base);
    logic [W-1:0] r;
    for (int i = 0; i < N_UNIT; i++) r[i*DW_DATA +: DW_DATA] = base + DW_DATA'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp1;
  int           pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    reset = 1'b1; start = 1'b0; k_len = '0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
    step(); step();
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_op_ready", W'(bus.op_ready), W'(0));
    chk("rst_res_valid", W'(bus.res_valid), W'(0));
    chk("rst_res_data", bus.res_data, '0);
    reset = 1'b0;
    step();

    // Job 1: k_len=3, a=(1..3)+lane, b=2, op_valid held high.
    start = 1'b1; k_len = 16'd3;
    step();
    start = 1'b0;
    chk("j1_busy", W'(busy), W'(1));
    chk("j1_op_ready", W'(bus.op_ready), W'(1));
    for (int k = 0; k < 3; k++) begin
      bus.op_valid = 1'b1; bus.op_a = lanes(DW_DATA'(k + 1)); bus.op_b = rep(32'd2);
      #1;
      chk("j1_pe_a", pe_a, lanes(DW_DATA'(k + 1)));
      chk("j1_pe_b", pe_b, rep(32'd2));
      step();
    end
    bus.op_valid = 1'b0; #1;
    chk("j1_drain_op_ready", W'(bus.op_ready), W'(0));
    chk("j1_drain_res_valid", W'(bus.res_valid), W'(0));
    chk("j1_drain_pe_a", pe_a, '0);
    step();
    exp1 = {32'd30, 32'd24, 32'd18, 32'd12};
    chk("j1_res_valid", W'(bus.res_valid), W'(1));
    chk("j1_res_data", bus.res_data, exp1);
    chk("j1_done_early", W'(done), W'(0));
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("j1_done", W'(done), W'(1));
    chk("j1_idle_busy", W'(busy), W'(0));
    chk("j1_idle_res_valid", W'(bus.res_valid), W'(0));
    step();
    chk("j1_done_once", W'(done), W'(0));
    chk("j1_acc_kept", bus.res_data, exp1);

    // Job 2: k_len=0.
    start = 1'b1; k_len = 16'd0;
    step();
    start = 1'b0;
    chk("j2_op_ready", W'(bus.op_ready), W'(0));
    chk("j2_res_valid", W'(bus.res_valid), W'(1));
    chk("j2_res_data", bus.res_data, '0);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("j2_done", W'(done), W'(1));
    chk("j2_busy", W'(busy), W'(0));

    // Job 3: k_len=4, gappy op_valid, a=b=3.
    start = 1'b1; k_len = 16'd4;
    step();
    start = 1'b0;
    bus.op_a = rep(32'd3); bus.op_b = rep(32'd3);
    for (int k = 0; k < 7; k++) begin
      bus.op_valid = (pat[k] != 0);
      #1;
      chk("j3_op_ready", W'(bus.op_ready), W'(1));
      chk("j3_pe_a", pe_a, (pat[k] != 0) ? rep(32'd3) : '0);
      chk("j3_pe_b", pe_b, (pat[k] != 0) ? rep(32'd3) : '0);
      step();
    end
    bus.op_valid = 1'b0;
    chk("j3_drain_op_ready", W'(bus.op_ready), W'(0));
    step();
    // Backpressure: result held 10 cycles; start is ignored.
    for (int k = 0; k < 10; k++) begin
      start = (k == 3); k_len = 16'd5;
      chk("j3_hold_valid", W'(bus.res_valid), W'(1));
      chk("j3_hold_data", bus.res_data, rep(32'd36));
      chk("j3_hold_busy", W'(busy), W'(1));
      chk("j3_hold_op_ready", W'(bus.op_ready), W'(0));
      step();
    end
    start = 1'b0;
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("j3_done", W'(done), W'(1));
    chk("j3_busy", W'(busy), W'(0));
    step();
    chk("j3_start_ignored_busy", W'(busy), W'(0));
    chk("j3_start_ignored_op_ready", W'(bus.op_ready), W'(0));

    // Job 4: wrap-around accumulation.
    start = 1'b1; k_len = 16'd2;
    step();
    start = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = rep(32'hFFFF_FFFF); bus.op_b = rep(32'd1);
    step(); step();
    bus.op_valid = 1'b0;
    step();
    chk("j4_res_valid", W'(bus.res_valid), W'(1));
    chk("j4_wrap", bus.res_data, rep(32'hFFFF_FFFE));
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("j4_done", W'(done), W'(1));

    // Job 5: reset after 2 of 5 beats, then k_len=1 job.
    start = 1'b1; k_len = 16'd5;
    step();
    start = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = rep(32'd9); bus.op_b = rep(32'd9);
    step(); step();
    bus.op_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("j5_rst_busy", W'(busy), W'(0));
    chk("j5_rst_done", W'(done), W'(0));
    chk("j5_rst_op_ready", W'(bus.op_ready), W'(0));
    chk("j5_rst_res_data", bus.res_data, '0);
    step();
    chk("j5_rst_no_done", W'(done), W'(0));
    chk("j5_rst_acc", bus.res_data, '0);
    start = 1'b1; k_len = 16'd1;
    step();
    start = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = rep(32'd5); bus.op_b = rep(32'd7);
    step();
    bus.op_valid = 1'b0;
    chk("j6_drain_res_valid", W'(bus.res_valid), W'(0));
    step();
    chk("j6_res_valid", W'(bus.res_valid), W'(1));
    chk("j6_res_data", bus.res_data, rep(32'd35));
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("j6_done", W'(done), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stc_pe_seq.md
Name: stc_pe_seq

Overview:
- Sequencer and accumulator wrapped around the unstructured-sparse PE multiplier array.
- Accepts one job of k_len operand beats over a valid/ready stream and drives each beat into the array.
- The array returns per-lane products with 1-cycle registered latency; this block accumulates them per lane and hands the accumulated vector out on a valid/ready result port.
- Sits between the operand gather/buffer logic and the writeback stage.

Parameters:
N_UNIT, 64, number of multiplier lanes in the PE array (N_PE*N).
DW_DATA, 32, lane data width; products and accumulators are DW_DATA bits.
DW_CNT, 16, width of the beat counter and of k_len.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
start  in  1  job request; sampled only in IDLE.
k_len  in  DW_CNT  number of operand beats in the job; sampled with start.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on the cycle the result handshake completes.
op_valid  in  1  operand beat valid.
op_ready  out  1  operand beat ready.
op_a  in  N_UNIT*DW_DATA  lane-packed A operands (lane i at [i*DW_DATA +: DW_DATA]).
op_b  in  N_UNIT*DW_DATA  lane-packed B operands.
pe_a  out  N_UNIT*DW_DATA  to PE array in_a.
pe_b  out  N_UNIT*DW_DATA  to PE array in_b.
pe_out  in  N_UNIT*DW_DATA  from PE array out; a product appears 1 cycle after its inputs.
res_valid  out  1  accumulated result valid.
res_ready  in  1  result consumer ready.
res_data  out  N_UNIT*DW_DATA  per-lane accumulators.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, op_ready=0, res_valid=0, all accumulators=0, beat counter=0, product-valid flag p_v=0.
- States:
  - IDLE: on start, latch k_len and clear the accumulators. If k_len==0, go to OUT; else go to RUN.
  - RUN: op_ready=1. A beat fires when op_valid&&op_ready. On each fire, cnt increments. On the fire where cnt==k_len-1, go to DRAIN. With no fire, hold RUN (op_valid gaps of any length are allowed).
  - DRAIN: op_ready=0. Exactly one cycle, then go to OUT.
  - OUT: res_valid=1 and res_data held stable. On res_valid&&res_ready, pulse done and go to IDLE. The accumulators keep their value until the next start.
- Array drive:
  - pe_a=op_a and pe_b=op_b when a beat fires; otherwise both are all zeros.
  - So the array only ever sees accepted data or zeros.
- Product tracking:
  - p_v is registered: p_v <= fire.
  - In a cycle with p_v=1, each lane does acc[i] <= acc[i] + pe_out[i], modulo 2^DW_DATA (wrap, no saturation).
  - DRAIN exists so the product of the last beat is accumulated before OUT.
- Latency: last beat fires in cycle T; its product is accumulated at the end of T+1 (DRAIN); res_valid is high from cycle T+2.
- Throughput: 1 beat/cycle in RUN. Job overhead is 1 (IDLE) + 1 (DRAIN) + ≥1 (OUT) cycles.
- start while busy is ignored and k_len is not re-sampled. start in the same cycle as the IDLE-bound OUT handshake is also ignored.
- Reset mid-operation:
  - Return to IDLE, clear accumulators, cnt and p_v. No done pulse.
  - The PE array shares the reset, so no stale product survives.
- k_len=0: no op_ready assertion; result is all zeros; res_valid is high 1 cycle after start.
- Overflow: k_len=2^DW_CNT-1 is legal; cnt never wraps within a job.

Test Plan:
- N_UNIT=4, k_len=3, lane i: a={1,2,3}+i, b=2 every beat, op_valid stuck high -> res_data lane i = 2*(6+3i) = {12,18,24,30}; res_valid asserted 2 cycles after the 3rd fire; done pulses once.
- k_len=0 start -> op_ready never high; res_valid next cycle with all-zero res_data; done on the first res_ready.
- k_len=4 with op_valid toggling 1,0,0,1,1,0,1, a=b=3 -> exactly 4 fires, lanes = 36; pe_a/pe_b are zero in non-fire cycles.
- res_ready held low 10 cycles in OUT -> res_valid and res_data stable, busy=1, a start pulse is ignored; res_ready=1 -> done, IDLE.
- Wrap: DW_DATA=32, k_len=2, a=0xFFFF_FFFF, b=1 -> lane = 0xFFFF_FFFE.
- reset asserted after 2 of 5 beats -> IDLE, busy=0, no done; a new job with k_len=1, a=5, b=7 yields 35 (no residue from the aborted job).
